wave_display_pipe: RTL

Downstream consumer of the wave-capture sample RAM (512 x 8, two 256-entry halves).
- Walks the half not being written, in step with the VGA scan position.
- Draws the captured waveform as a connected line in a 512x512 window.
- Reports wave_display_idle back to capture so it can swap halves between frames.
- RAM read is synchronous (1-cycle latency); this block pipelines x/y to match and registers its pixel outputs.

---
 rtl/wave_display_pkg.sv | 28 ++
 rtl/wave_line_compare.sv | 21 ++
 rtl/wave_display_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wave_display_pkg.sv
// Shared constants, FSM encoding and stage-1 record for the waveform display pipeline.
package wave_display_pkg;

    localparam logic [10:0] X_BASE_DEF = 11'd256;
    localparam int          WIN_W      = 512;
    localparam int          WIN_H      = 512;
    localparam logic [23:0] COLOR_DEF  = 24'hFFFFFF;
    localparam logic [23:0] GRID_COLOR = 24'h404040;

    typedef enum logic [1:0] {
        IDLE_S = 2'b01,
        DRAW_S = 2'b10
    } state_e;

    typedef struct packed {
        logic       in_win;
        logic       valid;
        logic [7:0] y_d;
        logic       col_new;
        logic       first;
    } s1_t;

    // Screen rows grow downward, so a large sample must land near the top.
    function automatic logic [7:0] plot_level(input logic [7:0] cur);
        return 8'd255 - cur;
    endfunction

endpackage

// File: rtl/wave_line_compare.sv
// Lit test for one pixel: is the row inside the span joining two plotted levels.
module wave_line_compare
    import wave_display_pkg::*;
(
    input  logic       en,
    input  logic [7:0] prev_t,
    input  logic [7:0] t,
    input  logic [7:0] y_d,
    output logic       lit
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo  = (prev_t < t) ? prev_t : t;
        hi  = (prev_t < t) ? t : prev_t;
        lit = en && (y_d >= lo) && (y_d <= hi);
    end

endmodule

// File: rtl/wave_display_pipe.sv
// Draws the captured half of the sample RAM as a connected line in a 512x512 window.
// Optional background grid when WAVE_DISPLAY_GRID_EN is defined.
module wave_display_pipe
    import wave_display_pkg::*;
#(
    parameter logic [23:0] COLOR  = COLOR_DEF,
    parameter logic [10:0] X_BASE = X_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    logic [10:0] xo_full;
    logic [8:0]  xo;
    logic        in_win;

    always_comb begin
        xo_full = x - X_BASE;
        xo      = xo_full[8:0];
        in_win  = valid && (x >= X_BASE) && (int'(xo_full) < WIN_W) && !y[9];
    end

    state_e      state_q, state_d;
    logic        idx_q, idx_d;
    logic [8:0]  addr_q, addr_d;
    s1_t         s1_q, s1_d;
    logic [7:0]  prev_t_q, prev_t_d;
    logic [23:0] rgb_q, rgb_d;
    logic        vp_q, vp_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE_S: begin
                if (valid && (y == 10'd0) && (x == 11'd0)) begin
                    state_d = DRAW_S;
                    idx_d   = ~read_index;
                end
            end
            DRAW_S: begin
                if (y == 10'(WIN_H)) state_d = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_comb begin
        addr_d = in_win ? {idx_q, xo[8:1]} : addr_q;
        s1_d.in_win  = in_win;
        s1_d.valid   = valid;
        s1_d.y_d     = y[8:1];
        s1_d.col_new = ~xo[0];
        s1_d.first   = (xo == 9'd0);
    end

    assign read_address = addr_d;

    // Stage 2: read_value belongs to the pixel held in s1_q.
    logic [7:0] t;
    logic [7:0] ref_t;
    logic       lit;
    logic       grid_hit;

    // prev_t holds the previous sample's level for both columns of a pair, so it
    // advances on the pair's second column; the first column of a line restarts it.
    always_comb begin
        t        = plot_level(read_value);
        ref_t    = s1_q.first ? t : prev_t_q;
        prev_t_d = prev_t_q;
        if (s1_q.in_win && (s1_q.first || !s1_q.col_new)) prev_t_d = t;
    end

    wave_line_compare u_cmp (
        .en     (s1_q.in_win),
        .prev_t (ref_t),
        .t      (t),
        .y_d    (s1_q.y_d),
        .lit    (lit)
    );

`ifdef WAVE_DISPLAY_GRID_EN
    logic grid_q, grid_d;

    always_comb grid_d = (xo[5:0] == 6'd0) || (y[5:0] == 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) grid_q <= 1'b0;
        else       grid_q <= grid_d;
    end

    assign grid_hit = s1_q.in_win && grid_q;
`else
    assign grid_hit = 1'b0;
`endif

    always_comb begin
        rgb_d = 24'h0;
        if (lit)           rgb_d = COLOR;
        else if (grid_hit) rgb_d = GRID_COLOR;
        vp_d = s1_q.valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE_S;
            idx_q    <= 1'b0;
            addr_q   <= 9'd0;
            s1_q     <= '0;
            prev_t_q <= 8'd0;
            rgb_q    <= 24'h0;
            vp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            s1_q     <= s1_d;
            prev_t_q <= prev_t_d;
            rgb_q    <= rgb_d;
            vp_q     <= vp_d;
        end
    end

    assign {r, g, b}         = rgb_q;
    assign valid_pixel       = vp_q;
    assign wave_display_idle = (state_q == IDLE_S);

endmodule
